// File: rtl/lcd_ctrl_pkg.sv
// Shared LCD controller definitions: reset-sequencer state encoding, PIO reset
// levels and default panel timing at a 50 MHz system clock.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_PRE,
    WAIT_PRE,
    WR_LOW,
    WAIT_LOW,
    WR_REL,
    WAIT_POST,
    RD_CHK,
    FIN
  } lcd_rst_state_t;

  // Level written to the PIO bit that drives the panel's active-low RESX pin
  localparam logic PIO_RST_DEASSERT = 1'b1;
  localparam logic PIO_RST_ASSERT   = 1'b0;

  // LT24 power-up timing at 50 MHz
  localparam int unsigned LCD_T_PRE_CYCLES  = 50000;    // 1 ms
  localparam int unsigned LCD_T_LOW_CYCLES  = 500000;   // 10 ms
  localparam int unsigned LCD_T_POST_CYCLES = 6000000;  // 120 ms
  localparam int unsigned LCD_CNT_W         = 24;

endpackage

// File: rtl/lcd_reset_sequencer_if.sv
// Avalon-MM link between the reset sequencer (master) and the LCD reset PIO
// (slave).
//   avm_address     word address
//   avm_write       write request
//   avm_writedata   write data
//   avm_read        read request
//   avm_readdata    read data, valid when avm_read=1 and avm_waitrequest=0
//   avm_waitrequest slave stall
interface lcd_reset_sequencer_if;

  logic [1:0]  avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter used to time LCD delays.
//   clk, reset_n  clock and asynchronous active-low reset
//   load          load load_value this cycle (takes priority over enable)
//   load_value    start value; the count reaches zero load_value cycles later
//   enable        decrement while non-zero
//   zero          count is zero
module lcd_delay_counter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_reset_sequencer.sv
// Avalon-MM master that drives the LT24 panel reset pulse through a 1-bit PIO:
// write 1, wait T_PRE; write 0, wait T_LOW; write 1, wait T_POST; optionally
// read the PIO back, then report done (success) or err (readback mismatch).
//   clk, reset_n  clock and asynchronous active-low reset
//   start         one-cycle launch request (ignored while busy)
//   busy          sequence in progress
//   done          sticky success flag
//   err           sticky readback-mismatch flag
//   avm           Avalon-MM master port to the reset PIO
module lcd_reset_sequencer
  import lcd_ctrl_pkg::*;
#(
  parameter logic [1:0]  PIO_ADDR      = 2'd0,
  parameter int unsigned T_PRE_CYCLES  = LCD_T_PRE_CYCLES,
  parameter int unsigned T_LOW_CYCLES  = LCD_T_LOW_CYCLES,
  parameter int unsigned T_POST_CYCLES = LCD_T_POST_CYCLES,
  parameter int unsigned CNT_W         = LCD_CNT_W,
  parameter bit          AUTO_START    = 1'b1,
  parameter bit          VERIFY        = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  lcd_reset_sequencer_if.master         avm
);

  // The counter holds T-1 so the wait spans exactly T cycles; T=0 acts as T=1.
  localparam logic [CNT_W-1:0] PRE_LOAD  =
    (T_PRE_CYCLES  == 0) ? '0 : CNT_W'(T_PRE_CYCLES  - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  =
    (T_LOW_CYCLES  == 0) ? '0 : CNT_W'(T_LOW_CYCLES  - 1);
  localparam logic [CNT_W-1:0] POST_LOAD =
    (T_POST_CYCLES == 0) ? '0 : CNT_W'(T_POST_CYCLES - 1);

  lcd_rst_state_t   state;
  logic             wr_bit;
  logic             auto_fired;
  logic             launch;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_value;

  assign avm.avm_address   = PIO_ADDR;
  assign avm.avm_writedata = {31'b0, wr_bit};

  // auto_fired is set on the first launch, so the auto term only fires once
  assign launch = start || (AUTO_START && !auto_fired);

  always_comb begin
    cnt_load  = avm.avm_write && !avm.avm_waitrequest;
    cnt_en    = (state == WAIT_PRE) || (state == WAIT_LOW) || (state == WAIT_POST);
    case (state)
      WR_PRE:  cnt_value = PRE_LOAD;
      WR_LOW:  cnt_value = LOW_LOAD;
      default: cnt_value = POST_LOAD;
    endcase
  end

  lcd_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (cnt_value),
    .enable     (cnt_en),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      wr_bit        <= 1'b0;
      auto_fired    <= 1'b0;
      avm.avm_write <= 1'b0;
      avm.avm_read  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (launch) begin
            state         <= WR_PRE;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            auto_fired    <= 1'b1;
            avm.avm_write <= 1'b1;
            wr_bit        <= PIO_RST_DEASSERT;
          end
        end
        WR_PRE: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            state         <= WAIT_PRE;
          end
        end
        WAIT_PRE: begin
          if (cnt_zero) begin
            avm.avm_write <= 1'b1;
            wr_bit        <= PIO_RST_ASSERT;
            state         <= WR_LOW;
          end
        end
        WR_LOW: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            state         <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (cnt_zero) begin
            avm.avm_write <= 1'b1;
            wr_bit        <= PIO_RST_DEASSERT;
            state         <= WR_REL;
          end
        end
        WR_REL: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            state         <= WAIT_POST;
          end
        end
        WAIT_POST: begin
          if (cnt_zero) begin
            if (VERIFY) begin
              avm.avm_read <= 1'b1;
              state        <= RD_CHK;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        RD_CHK: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            busy         <= 1'b0;
            state        <= FIN;
            if (avm.avm_readdata[0] == PIO_RST_DEASSERT) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
